// File: rtl/pico_pkg.sv
// Shared definitions for the pico execute stage (ALU flag layout, divider FSM states).
package pico_pkg;

   localparam int unsigned pico_N = 8;

   // Flag nibble layout {Z,N,C,V}, common to the ALU and the divider.
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StDiv,
      StFix,
      StDone
   } pico_div_state_t;

endpackage

// File: rtl/pico_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module pico_div_step #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] rem,
   input  logic         din,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_next,
   output logic         q_bit
);

   logic [N:0]   shifted;
   logic [N-1:0] diff;

   // Keep the difference only when it is non-negative; a kept result always fits in N bits.
   always_comb begin
      shifted  = {rem, din};
      q_bit    = (shifted >= {1'b0, divisor});
      diff     = shifted[N-1:0] - divisor;
      rem_next = q_bit ? diff : shifted[N-1:0];
   end

endmodule

// File: rtl/pico_div.sv
// Iterative N-bit signed/unsigned divider with start/ready handshake and ALU-style flags.
module pico_div
   import pico_pkg::*;
#(
   parameter int unsigned N = pico_N
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         signed_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [N-1:0] q_o,
   output logic [N-1:0] r_o,
   output logic [3:0]   flags_o
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};

   pico_div_state_t state_q, state_d;

   logic [N-1:0]    a_q, b_q;      // operands as presented
   logic            sgn_q;
   logic [N-1:0]    rem_q, quo_q;  // partial remainder / dividend shifting into quotient
   logic [N-1:0]    dvs_q;         // divisor magnitude
   logic            q_neg_q, r_neg_q;
   logic [CntW-1:0] cnt_q;

   logic [N-1:0]    step_rem;
   logic            step_bit;
   logic [N-1:0]    fix_q, fix_r;
   logic [3:0]      fix_flags;
   logic            fix_c, fix_v;

   pico_div_step #(
      .N (N)
   ) u_step (
      .rem      (rem_q),
      .din      (quo_q[N-1]),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .q_bit    (step_bit)
   );

   // FSM state register; reset wins over a coincident start.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fixed path IDLE-PREP-DIV(xN)-FIX-DONE for every operation.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StPrep;
         StPrep:  state_d = StDiv;
         StDiv:   if (cnt_q == '0) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign ready_o = (state_q == StIdle);
   assign valid_o = (state_q == StDone);

   // Sign fix-up, special cases and flags, registered to the outputs in FIX.
   always_comb begin
      fix_q = q_neg_q ? -quo_q : quo_q;
      fix_r = r_neg_q ? -rem_q : rem_q;
      fix_c = 1'b0;
      fix_v = 1'b0;
      if (b_q == '0) begin
         fix_q = '1;
         fix_r = a_q;
         fix_c = 1'b1;
      end else if (sgn_q && (a_q == MinNeg) && (b_q == '1)) begin
         fix_q = MinNeg;
         fix_r = '0;
         fix_v = 1'b1;
      end
      fix_flags         = '0;
      fix_flags[FLAG_Z] = (fix_q == '0);
      fix_flags[FLAG_N] = fix_q[N-1];
      fix_flags[FLAG_C] = fix_c;
      fix_flags[FLAG_V] = fix_v;
   end

   // Datapath: operand capture, magnitude prep, iteration and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         cnt_q   <= '0;
         q_o     <= '0;
         r_o     <= '0;
         flags_o <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  a_q   <= a_i;
                  b_q   <= b_i;
                  sgn_q <= signed_i;
               end
            end
            StPrep: begin
               rem_q <= '0;
               cnt_q <= CntW'(N - 1);
               if (sgn_q) begin
                  quo_q   <= a_q[N-1] ? -a_q : a_q;
                  dvs_q   <= b_q[N-1] ? -b_q : b_q;
                  q_neg_q <= a_q[N-1] ^ b_q[N-1];
                  r_neg_q <= a_q[N-1];
               end else begin
                  quo_q   <= a_q;
                  dvs_q   <= b_q;
                  q_neg_q <= 1'b0;
                  r_neg_q <= 1'b0;
               end
            end
            StDiv: begin
               rem_q <= step_rem;
               quo_q <= {quo_q[N-2:0], step_bit};
               if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
            end
            StFix: begin
               q_o     <= fix_q;
               r_o     <= fix_r;
               flags_o <= fix_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pico_div.sv
// Scoreboard bench for pico_div: driver queues expected results, monitor checks on valid.
module tb_pico_div;

   typedef struct {
      logic [7:0]  q;
      logic [7:0]  r;
      logic [3:0]  f;
      int unsigned t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sgn = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       ready, valid;
   logic [7:0] q, r;
   logic [3:0] flags;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   exp_t        last;
   exp_t        mon_e;

   pico_div #(
      .N (8)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .signed_i (sgn),
      .a_i      (a),
      .b_i      (b),
      .ready_o  (ready),
      .valid_o  (valid),
      .q_o      (q),
      .r_o      (r),
      .flags_o  (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] eq, input logic [7:0] er, input logic [3:0] ef);
      exp_t e;
      e.q = eq;
      e.r = er;
      e.f = ef;
      e.t = 0;
      return e;
   endfunction

   // Reference: plain integer division; SV / and % truncate toward zero like the spec.
   function automatic exp_t model(input logic s, input logic [7:0] aa, input logic [7:0] bb);
      int   sa, sd, qi, ri;
      logic c, v;
      exp_t e;
      c = 1'b0;
      v = 1'b0;
      if (bb == 8'd0) begin
         e.q = 8'hFF;
         e.r = aa;
         c   = 1'b1;
      end else if (s) begin
         sa = int'($signed(aa));
         sd = int'($signed(bb));
         if (sa == -128 && sd == -1) begin
            e.q = 8'h80;
            e.r = 8'h00;
            v   = 1'b1;
         end else begin
            qi  = sa / sd;
            ri  = sa % sd;
            e.q = qi[7:0];
            e.r = ri[7:0];
         end
      end else begin
         e.q = aa / bb;
         e.r = aa % bb;
      end
      e.f = {(e.q == 8'd0), e.q[7], c, v};
      e.t = 0;
      return e;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: ready still 0 after 40 cycles");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: %0d results outstanding", sb.size());
      end
   endtask

   // Issue one operation from a negedge; record the accepting edge for the latency check.
   task automatic do_op(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                        input exp_t e_in);
      exp_t e;
      e = e_in;
      wait_ready();
      sgn   = s;
      a     = aa;
      b     = bb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e.t   = cyc;
      check("accept_ready_low", 32'(ready), 32'd0);
      sb.push_back(e);
      last = e;
   endtask

   // Monitor: every valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("q", 32'(q), 32'(mon_e.q));
            check("r", 32'(r), 32'(mon_e.r));
            check("flags", 32'(flags), 32'(mon_e.f));
            check("latency", cyc - mon_e.t, 32'd10);
            check("ready_in_done", 32'(ready), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, prev;
      logic        s;
      logic [7:0]  ra, rb;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_r", 32'(r), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with hand-derived results.
      do_op(1'b0, 8'd100, 8'd7, mk(8'h0E, 8'h02, 4'b0000));
      do_op(1'b1, 8'h9C, 8'h07, mk(8'hF2, 8'hFE, 4'b0100));
      do_op(1'b1, 8'h64, 8'hF9, mk(8'hF2, 8'h02, 4'b0100));
      do_op(1'b0, 8'h05, 8'h00, mk(8'hFF, 8'h05, 4'b0110));
      do_op(1'b1, 8'h05, 8'h00, mk(8'hFF, 8'h05, 4'b0110));
      do_op(1'b1, 8'h80, 8'hFF, mk(8'h80, 8'h00, 4'b0101));
      do_op(1'b0, 8'h80, 8'hFF, mk(8'h00, 8'h80, 4'b1000));
      wait_idle();

      // Start pulse during a busy operation is dropped.
      do_op(1'b1, 8'hC8, 8'h05, model(1'b1, 8'hC8, 8'h05));
      repeat (3) @(negedge clk);
      sgn   = 1'b0;
      a     = 8'h11;
      b     = 8'h22;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (14) @(negedge clk);
      // Outputs hold after the operation.
      check("hold_q", 32'(q), 32'(last.q));
      check("hold_r", 32'(r), 32'(last.r));
      check("hold_flags", 32'(flags), 32'(last.f));

      // start held high: one accept every 12 cycles.
      prev = 0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ready();
         s   = 1'(k);
         ra  = 8'(8'd200 - 8'(k * 37));
         rb  = 8'(8'd9 + 8'(k));
         sgn = s;
         a   = ra;
         b   = rb;
         @(negedge clk);
         t0 = cyc;
         check("b2b_accept", 32'(ready), 32'd0);
         mon_e   = model(s, ra, rb);
         mon_e.t = t0;
         sb.push_back(mon_e);
         if (k > 0) check("b2b_period", t0 - prev, 32'd12);
         prev = t0;
      end
      start = 1'b0;
      wait_idle();

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         s  = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = 8'($urandom);
         case ($urandom_range(0, 9))
            0: rb = 8'h00;
            1: begin ra = 8'h80; rb = 8'hFF; end
            2: rb = 8'h01;
            default: ;
         endcase
         do_op(s, ra, rb, model(s, ra, rb));
      end
      wait_idle();

      // Reset at cycle 5 of an operation aborts it with no valid.
      do_op(1'b0, 8'hF7, 8'h03, model(1'b0, 8'hF7, 8'h03));
      wait_idle();
      wait_ready();
      sgn   = 1'b0;
      a     = 8'h77;
      b     = 8'h03;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_q", 32'(q), 32'd0);
      check("abort_r", 32'(r), 32'd0);
      check("abort_flags", 32'(flags), 32'd0);
      repeat (15) @(negedge clk);
      do_op(1'b0, 8'h00, 8'h05, mk(8'h00, 8'h00, 4'b1000));
      wait_idle();

      // Reset and start together: start dropped.
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'h33;
      b     = 8'h04;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_ready", 32'(ready), 32'd1);
      repeat (14) @(negedge clk);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
